// File: rtl/tia_sprite_graphics.sv
// Player-sprite engine: position counter, copy/size decode, graphics scan FSM
// and vertically-delayed graphics pair. Optional motion: TIA_SPRITE_HMOVE_EN.
module tia_sprite_graphics #(
  parameter int GR_WIDTH = 8,
  parameter int LINE_LEN = 160,
  parameter int CNT_W    = 8,
  localparam int D_W     = (GR_WIDTH > 8) ? GR_WIDTH : 8
) (
  input  logic           clkp,
  input  logic           rst,
  input  logic           pix_en,
  input  logic [D_W-1:0] d,
  input  logic           wr_grp,
  input  logic           wr_gry,
  input  logic           wr_nusiz,
  input  logic           wr_refp,
  input  logic           wr_vdel,
  input  logic           wr_resp,
`ifdef TIA_SPRITE_HMOVE_EN
  input  logic           wr_hmp,
  input  logic           hmove,
`endif
  output logic           px,
  output logic           drawing
);

  localparam int BI_W = $clog2(GR_WIDTH);
  localparam logic [CNT_W-1:0] LAST_POS = CNT_W'(LINE_LEN - 1);
  localparam logic [CNT_W-1:0] P16      = CNT_W'(16);
  localparam logic [CNT_W-1:0] P32      = CNT_W'(32);
  localparam logic [CNT_W-1:0] P64      = CNT_W'(64);
  localparam logic HAS16 = (LINE_LEN > 16);
  localparam logic HAS32 = (LINE_LEN > 32);
  localparam logic HAS64 = (LINE_LEN > 64);
  localparam logic [BI_W-1:0] BI_MSB = BI_W'(GR_WIDTH - 1);

  typedef enum logic {S_IDLE = 1'b0, S_DRAW = 1'b1} state_t;

  state_t              state_q;
  logic [BI_W-1:0]     bit_idx_q;
  logic [1:0]          stretch_cnt_q;
  logic                px_q;
  logic [CNT_W-1:0]    pos_q, pos_d;
  logic [GR_WIDTH-1:0] new_q, old_q;
  logic [2:0]          nusiz_q;
  logic                refp_q, vdel_q;

  logic [GR_WIDTH-1:0] gr;
  logic [1:0]          stretch_m1;
  logic                hit, step, start, last_bit;
  logic [BI_W-1:0]     first_bit;
  logic                unused_d;

  assign unused_d = ^d;

  // A position step is either a visible pixel or a blank-time motion clock.
`ifdef TIA_SPRITE_HMOVE_EN
  logic [3:0] hm_q;
  logic [4:0] mot_cnt_q;
  logic       mot_step;

  assign mot_step = !pix_en && (mot_cnt_q != 5'd0);
  assign step     = pix_en || mot_step;

  always_ff @(posedge clkp) begin
    if (rst) begin
      hm_q      <= 4'd0;
      mot_cnt_q <= 5'd0;
    end else begin
      if (wr_hmp) hm_q <= d[7:4];
      if (wr_resp)       mot_cnt_q <= 5'd0;
      else if (hmove)    mot_cnt_q <= 5'd8 - {hm_q[3], hm_q};
      else if (mot_step) mot_cnt_q <= mot_cnt_q - 5'd1;
    end
  end
`else
  assign step = pix_en;
`endif

  assign gr        = vdel_q ? old_q : new_q;
  assign first_bit = refp_q ? '0 : BI_MSB;
  assign last_bit  = refp_q ? (bit_idx_q == BI_MSB) : (bit_idx_q == '0);

  always_comb begin
    hit        = (pos_q == '0);
    stretch_m1 = 2'd0;
    case (nusiz_q)
      3'b001:  hit = hit || (HAS16 && pos_q == P16);
      3'b010:  hit = hit || (HAS32 && pos_q == P32);
      3'b011:  hit = hit || (HAS16 && pos_q == P16) || (HAS32 && pos_q == P32);
      3'b100:  hit = hit || (HAS64 && pos_q == P64);
      3'b101:  stretch_m1 = 2'd1;
      3'b110:  hit = hit || (HAS32 && pos_q == P32) || (HAS64 && pos_q == P64);
      3'b111:  stretch_m1 = 2'd3;
      default: ;
    endcase
  end

  assign start = step && hit;

  always_comb begin
    pos_d = pos_q;
    if (wr_resp)   pos_d = '0;
    else if (step) pos_d = (pos_q == LAST_POS) ? '0 : pos_q + 1'b1;
  end

  always_ff @(posedge clkp) begin
    if (rst) begin
      pos_q   <= '0;
      new_q   <= '0;
      old_q   <= '0;
      nusiz_q <= 3'd0;
      refp_q  <= 1'b0;
      vdel_q  <= 1'b0;
    end else begin
      pos_q <= pos_d;
      if (wr_grp)   new_q   <= d[GR_WIDTH-1:0];
      if (wr_gry)   old_q   <= new_q;
      if (wr_nusiz) nusiz_q <= d[2:0];
      if (wr_refp)  refp_q  <= d[3];
      if (wr_vdel)  vdel_q  <= d[0];
    end
  end

  // Scan FSM; a start in DRAW still emits the current pixel, then reloads.
  always_ff @(posedge clkp) begin
    if (rst) begin
      state_q       <= S_IDLE;
      bit_idx_q     <= '0;
      stretch_cnt_q <= 2'd0;
      px_q          <= 1'b0;
    end else begin
      if (pix_en) begin
        if (state_q == S_DRAW) begin
          px_q <= gr[bit_idx_q];
          if (stretch_cnt_q >= stretch_m1) begin
            stretch_cnt_q <= 2'd0;
            if (last_bit) state_q <= S_IDLE;
            else if (refp_q) bit_idx_q <= bit_idx_q + 1'b1;
            else bit_idx_q <= bit_idx_q - 1'b1;
          end else begin
            stretch_cnt_q <= stretch_cnt_q + 2'd1;
          end
        end else begin
          px_q <= 1'b0;
        end
      end
      if (start) begin
        state_q       <= S_DRAW;
        bit_idx_q     <= first_bit;
        stretch_cnt_q <= 2'd0;
      end
    end
  end

  assign px      = px_q;
  assign drawing = (state_q == S_DRAW);

endmodule

// File: tb/tb_tia_sprite_graphics.sv
// Bench for tia_sprite_graphics: directed scenarios plus random traffic,
// checked each cycle against a pixel-count reference model.
module tb_tia_sprite_graphics;

  localparam int W_GRP  = 1;
  localparam int W_GRY  = 2;
  localparam int W_NUS  = 4;
  localparam int W_REFP = 8;
  localparam int W_VDEL = 16;
  localparam int W_RESP = 32;
  localparam int W_RST  = 64;

  logic       clkp = 1'b0;
  logic       rst = 1'b0, pix_en = 1'b0;
  logic [7:0] d = 8'h00;
  logic       wr_grp = 0, wr_gry = 0, wr_nusiz = 0, wr_refp = 0, wr_vdel = 0, wr_resp = 0;
  logic       px, drawing;

  int checks = 0;
  int errors = 0;

  // reference model state
  int         m_pos = 0;
  logic [7:0] m_new = 0, m_old = 0;
  logic [2:0] m_nusiz = 0;
  logic       m_refp = 0, m_vdel = 0;
  logic       m_active = 0;
  int         m_n = 0;
  logic       m_px = 0;

  logic rec_px [0:319];
  logic [7:0] pat;

  always #5 clkp = ~clkp;

  tia_sprite_graphics dut (
    .clkp(clkp), .rst(rst), .pix_en(pix_en), .d(d),
    .wr_grp(wr_grp), .wr_gry(wr_gry), .wr_nusiz(wr_nusiz),
    .wr_refp(wr_refp), .wr_vdel(wr_vdel), .wr_resp(wr_resp),
    .px(px), .drawing(drawing)
  );

  function automatic logic is_start(input int pos, input logic [2:0] nus);
    int starts[$];
    starts = {0};
    case (nus)
      3'b001: starts = {0, 16};
      3'b010: starts = {0, 32};
      3'b011: starts = {0, 16, 32};
      3'b100: starts = {0, 64};
      3'b110: starts = {0, 32, 64};
      default: starts = {0};
    endcase
    foreach (starts[i]) if (starts[i] == pos) return 1'b1;
    return 1'b0;
  endfunction

  function automatic int stretch_of(input logic [2:0] nus);
    if (nus == 3'b101) return 2;
    if (nus == 3'b111) return 4;
    return 1;
  endfunction

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  // One colour clock: drive, advance the model on the edge, compare after it.
  task automatic cycle(input logic pe, input logic [7:0] dv, input int wr);
    logic       st;
    int         s, k;
    logic [7:0] gr;
    pix_en = pe; d = dv;
    wr_grp = (wr & W_GRP) != 0;  wr_gry  = (wr & W_GRY) != 0;
    wr_nusiz = (wr & W_NUS) != 0; wr_refp = (wr & W_REFP) != 0;
    wr_vdel = (wr & W_VDEL) != 0; wr_resp = (wr & W_RESP) != 0;
    rst = (wr & W_RST) != 0;
    st = pe && is_start(m_pos, m_nusiz);
    s  = stretch_of(m_nusiz);
    gr = m_vdel ? m_old : m_new;
    @(posedge clkp);
    if (rst) begin
      m_pos = 0; m_new = 0; m_old = 0; m_nusiz = 0; m_refp = 0; m_vdel = 0;
      m_active = 0; m_n = 0; m_px = 0;
    end else begin
      if (pe) begin
        if (m_active) begin
          k = m_n / s;
          m_px = gr[m_refp ? k : 7 - k];
          m_n++;
          if (m_n == 8 * s) m_active = 0;
        end else begin
          m_px = 0;
        end
      end
      if (st) begin m_active = 1; m_n = 0; end
      if (wr_resp) m_pos = 0;
      else if (pe) m_pos = (m_pos + 1) % 160;
      if (wr_gry) m_old = m_new;
      if (wr_grp) m_new = dv;
      if (wr_nusiz) m_nusiz = dv[2:0];
      if (wr_refp) m_refp = dv[3];
      if (wr_vdel) m_vdel = dv[0];
    end
    #1;
    check("px", {31'b0, px}, {31'b0, m_px});
    check("drawing", {31'b0, drawing}, {31'b0, m_active});
  endtask

  task automatic run_pix(input int n, output int ones, output int draws);
    ones = 0; draws = 0;
    for (int i = 0; i < n; i++) begin
      cycle(1'b1, 8'h00, 0);
      if (i < 320) rec_px[i] = px;
      ones += int'(px);
      draws += int'(drawing);
    end
  endtask

  initial begin
    int ones, draws, wr;
    logic pe;
    logic [7:0] dv;

    // reset state
    cycle(1'b0, 8'h00, W_RST);
    cycle(1'b0, 8'h00, W_RST);
    check("reset_px", {31'b0, px}, 32'd0);
    check("reset_drawing", {31'b0, drawing}, 32'd0);

    // single copy of 0xA5 over two lines
    cycle(1'b0, 8'hA5, W_GRP);
    cycle(1'b0, 8'h00, W_RESP);
    run_pix(320, ones, draws);
    pat = 8'hA5;
    for (int i = 0; i < 320; i++) begin
      int p;
      p = i % 160;
      check("a5_pattern", {31'b0, rec_px[i]},
            (p >= 1 && p <= 8) ? {31'b0, pat[8 - p]} : 32'd0);
    end
    check("a5_ones", ones, 8);
    check("a5_draw", draws, 16);

    // three close copies, reflected 0x81
    cycle(1'b0, 8'h03, W_NUS);
    cycle(1'b0, 8'h08, W_REFP);
    cycle(1'b0, 8'h81, W_GRP);
    cycle(1'b0, 8'h00, W_RESP);
    run_pix(160, ones, draws);
    check("three_copy_draw", draws, 24);
    check("three_copy_ones", ones, 6);
    for (int c = 0; c < 3; c++) begin
      check("three_copy_first", {31'b0, rec_px[1 + 16 * c]}, 32'd1);
      check("three_copy_last", {31'b0, rec_px[8 + 16 * c]}, 32'd1);
    end

    // quad-width copy of 0xF0
    cycle(1'b0, 8'h07, W_NUS);
    cycle(1'b0, 8'h00, W_REFP);
    cycle(1'b0, 8'hF0, W_GRP);
    cycle(1'b0, 8'h00, W_RESP);
    run_pix(40, ones, draws);
    for (int i = 1; i <= 32; i++)
      check("quad_pattern", {31'b0, rec_px[i]}, (i <= 16) ? 32'd1 : 32'd0);
    check("quad_draw", draws, 32);

    // vertical delay
    cycle(1'b0, 8'h00, W_NUS);
    cycle(1'b0, 8'h01, W_VDEL);
    cycle(1'b0, 8'h3C, W_GRP);
    cycle(1'b0, 8'h00, W_RESP);
    run_pix(160, ones, draws);
    check("vdel_before_gry", ones, 0);
    cycle(1'b0, 8'h00, W_GRY);
    run_pix(160, ones, draws);
    check("vdel_after_gry", ones, 4);
    check("vdel_bit_c", {31'b0, rec_px[3]}, 32'd1);
    cycle(1'b0, 8'hFF, W_GRP | W_GRY);
    run_pix(160, ones, draws);
    check("vdel_old_3c", ones, 4);
    cycle(1'b0, 8'h00, W_VDEL);
    run_pix(160, ones, draws);
    check("vdel_off_new_ff", ones, 8);

    // position reset mid-scan, then reset mid-draw
    cycle(1'b0, 8'h00, W_RESP);
    run_pix(4, ones, draws);
    cycle(1'b1, 8'h00, W_RESP);
    run_pix(20, ones, draws);
    cycle(1'b0, 8'h00, W_RESP);
    run_pix(3, ones, draws);
    check("pre_rst_drawing", {31'b0, drawing}, 32'd1);
    cycle(1'b1, 8'h00, W_RST);
    check("rst_mid_px", {31'b0, px}, 32'd0);
    check("rst_mid_drawing", {31'b0, drawing}, 32'd0);
    run_pix(160, ones, draws);
    check("post_rst_ones", ones, 0);
    check("post_rst_draw", draws, 8);

    // random traffic
    for (int i = 0; i < 4000; i++) begin
      logic may_cfg;
      pe = ($urandom_range(0, 3) != 0);
      dv = 8'($urandom);
      wr = 0;
      if ($urandom_range(0, 7) == 0) wr |= W_GRP;
      if ($urandom_range(0, 15) == 0) wr |= W_GRY;
      if ($urandom_range(0, 31) == 0) wr |= W_VDEL;
      if ($urandom_range(0, 199) == 0) wr |= W_RESP;
      may_cfg = !m_active && !(pe && is_start(m_pos, m_nusiz));
      if (may_cfg && $urandom_range(0, 15) == 0) wr |= W_NUS;
      if (may_cfg && $urandom_range(0, 15) == 0) wr |= W_REFP;
      if ($urandom_range(0, 1999) == 0) wr = W_RST;
      cycle(pe, dv, wr);
    end

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
